// File: rtl/fpu_mult_rnd_if.sv
// Request/response bundle for the parametrised FP multiplier.
// The requester (master) drives start/a/b/rm; the multiplier (slave) returns status, result and flags.
interface fpu_mult_rnd_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   rm;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         overflow;
    logic         underflow;
    logic         invalid;
    logic         inexact;

    modport master (
        output start, a, b, rm,
        input  busy, done, result, overflow, underflow, invalid, inexact
    );

    modport slave (
        input  start, a, b, rm,
        output busy, done, result, overflow, underflow, invalid, inexact
    );
endinterface

// File: rtl/fpu_mult_rnd.sv
// Multi-cycle IEEE-754 multiplier with DAZ/FTZ, five rounding modes and full flags.
// One operation at a time: IDLE -> UNPACK -> (MUL -> NORM -> ROUND |) -> DONE.
module fpu_mult_rnd #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic          clk,
    input  logic          rst_n,
    fpu_mult_rnd_if.slave bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * (MAN_W + 1);
    localparam int XW = EXP_W + 2;

    localparam logic [EXP_W-1:0]        EXP_ONES = '1;
    localparam logic [EXP_W-1:0]        EXP_MAXF = EXP_ONES - 1'b1;
    localparam logic signed [XW-1:0]    BIAS     = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [XW-1:0]    EMAX     = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0]    EXP_ONE  = XW'(1);

    typedef enum logic [2:0] {IDLE, UNPACK, MUL, NORM, ROUND, DONE} state_t;

    state_t state_q, state_d;

    logic [W-1:0]          a_q, b_q;
    logic [2:0]            rm_q;
    logic [PW-1:0]         prod_q;
    logic signed [XW-1:0]  exp_q;
    logic [MAN_W-1:0]      frac_q;
    logic                  grd_q, rnd_q, stk_q;
    logic [W-1:0]          result_q;
    logic                  ov_q, un_q, inv_q, inx_q;

    // Operand classification
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             sign;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
    logic             inf_zero, special;

    assign ea     = a_q[W-2 -: EXP_W];
    assign eb     = b_q[W-2 -: EXP_W];
    assign fa     = a_q[MAN_W-1:0];
    assign fb     = b_q[MAN_W-1:0];
    assign sign   = a_q[W-1] ^ b_q[W-1];

    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == EXP_ONES) && (fa == '0);
    assign b_inf  = (eb == EXP_ONES) && (fb == '0);
    assign a_nan  = (ea == EXP_ONES) && (fa != '0);
    assign b_nan  = (eb == EXP_ONES) && (fb != '0);
    assign a_snan = a_nan && !fa[MAN_W-1];
    assign b_snan = b_nan && !fb[MAN_W-1];

    assign inf_zero = (a_inf && b_zero) || (a_zero && b_inf);
    assign special  = a_zero || b_zero || a_inf || b_inf || a_nan || b_nan;

    logic [W-1:0] spec_res;
    logic         spec_inv;

    always_comb begin
        spec_res = {sign, {(W-1){1'b0}}};
        spec_inv = a_snan || b_snan || inf_zero;
        if (a_nan || b_nan || inf_zero)
            spec_res = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
        else if (a_inf || b_inf)
            spec_res = {sign, EXP_ONES, {MAN_W{1'b0}}};
    end

    // Normalised view of the product with the leading one dropped
    logic [PW-2:0] nprod;
    assign nprod = prod_q[PW-1] ? prod_q[PW-2:0] : {prod_q[PW-3:0], 1'b0};

    // Rounding
    logic                 any_lost, inc, carry;
    logic [MAN_W-1:0]     frac_rnd;
    logic signed [XW-1:0] exp_rnd;
    logic                 ovf, unf;
    logic [W-1:0]         rnd_res;

    always_comb begin
        any_lost = grd_q | rnd_q | stk_q;
        case (rm_q)
            3'b001:  inc = 1'b0;
            3'b010:  inc = any_lost & sign;
            3'b011:  inc = any_lost & ~sign;
            3'b100:  inc = grd_q;
            default: inc = grd_q & (rnd_q | stk_q | frac_q[0]);
        endcase
        // A carry out of the fraction leaves it all-zero, i.e. 1.0 x 2^(e+1)
        {carry, frac_rnd} = {1'b0, frac_q} + (MAN_W+1)'(inc);
        exp_rnd = carry ? exp_q + EXP_ONE : exp_q;
        ovf = (exp_rnd >= EMAX);
        unf = (exp_rnd < EXP_ONE);

        rnd_res = {sign, exp_rnd[EXP_W-1:0], frac_rnd};
        if (ovf) begin
            case (rm_q)
                3'b001:  rnd_res = {sign, EXP_MAXF, {MAN_W{1'b1}}};
                3'b010:  rnd_res = sign ? {1'b1, EXP_ONES, {MAN_W{1'b0}}}
                                        : {1'b0, EXP_MAXF, {MAN_W{1'b1}}};
                3'b011:  rnd_res = sign ? {1'b1, EXP_MAXF, {MAN_W{1'b1}}}
                                        : {1'b0, EXP_ONES, {MAN_W{1'b0}}};
                default: rnd_res = {sign, EXP_ONES, {MAN_W{1'b0}}};
            endcase
        end else if (unf) begin
            rnd_res = {sign, {(W-1){1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = UNPACK;
            UNPACK:  state_d = special ? DONE : MUL;
            MUL:     state_d = NORM;
            NORM:    state_d = ROUND;
            ROUND:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            rm_q     <= '0;
            prod_q   <= '0;
            exp_q    <= '0;
            frac_q   <= '0;
            grd_q    <= 1'b0;
            rnd_q    <= 1'b0;
            stk_q    <= 1'b0;
            result_q <= '0;
            ov_q     <= 1'b0;
            un_q     <= 1'b0;
            inv_q    <= 1'b0;
            inx_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    a_q  <= bus.a;
                    b_q  <= bus.b;
                    rm_q <= bus.rm;
                end
                UNPACK: if (special) begin
                    result_q <= spec_res;
                    ov_q     <= 1'b0;
                    un_q     <= 1'b0;
                    inv_q    <= spec_inv;
                    inx_q    <= 1'b0;
                end
                MUL: begin
                    prod_q <= PW'({1'b1, fa}) * PW'({1'b1, fb});
                    exp_q  <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
                end
                NORM: begin
                    frac_q <= nprod[PW-2 -: MAN_W];
                    grd_q  <= nprod[MAN_W];
                    rnd_q  <= nprod[MAN_W-1];
                    stk_q  <= |nprod[MAN_W-2:0];
                    if (prod_q[PW-1]) exp_q <= exp_q + EXP_ONE;
                end
                ROUND: begin
                    result_q <= rnd_res;
                    ov_q     <= ovf;
                    un_q     <= unf && !ovf;
                    inv_q    <= 1'b0;
                    inx_q    <= any_lost | ovf | unf;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.overflow  = ov_q;
    assign bus.underflow = un_q;
    assign bus.invalid   = inv_q;
    assign bus.inexact   = inx_q;
endmodule

// File: tb/tb_fpu_mult_rnd.sv
// Scoreboarded bench: single- and half-precision multipliers checked against an arithmetic model.
module tb_fpu_mult_rnd;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fpu_mult_rnd_if #(.EXP_W(8), .MAN_W(23)) bus_s ();
    fpu_mult_rnd_if #(.EXP_W(5), .MAN_W(10)) bus_h ();

    fpu_mult_rnd #(.EXP_W(8), .MAN_W(23)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));
    fpu_mult_rnd #(.EXP_W(5), .MAN_W(10)) dut_h (.clk(clk), .rst_n(rst_n), .bus(bus_h));

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  fl;   // {overflow, underflow, invalid, inexact}
        logic        spec;
    } exp_t;

    exp_t q_s[$];
    exp_t q_h[$];
    exp_t e_s, e_h;
    int n_chk = 0;
    int n_pass = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    // Reference: exact integer product, rounding decided from the discarded remainder
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] rm_in, input int ew, input int mw);
        exp_t r;
        longint one, emax, bias, fa, fb, p, q, rem, half, sgl, maxf, inf;
        int ea, eb, e, sh, rm;
        bit sa, sb, sg, za, zb, ia, ib, na, nb, sna, snb, inc, inx;
        one  = 1;
        emax = (one << ew) - 1;
        bias = (one << (ew - 1)) - 1;
        fa = a & ((one << mw) - 1);
        fb = b & ((one << mw) - 1);
        ea = int'((longint'(a) >> mw) & emax);
        eb = int'((longint'(b) >> mw) & emax);
        sa = a[ew+mw];
        sb = b[ew+mw];
        sg = sa ^ sb;
        sgl = longint'(sg) << (ew + mw);
        rm = (rm_in > 4) ? 0 : int'(rm_in);
        r = '0;
        za = (ea == 0);  zb = (eb == 0);
        ia = (ea == emax) && (fa == 0);  ib = (eb == emax) && (fb == 0);
        na = (ea == emax) && (fa != 0);  nb = (eb == emax) && (fb != 0);
        sna = na && (((fa >> (mw - 1)) & 1) == 0);
        snb = nb && (((fb >> (mw - 1)) & 1) == 0);
        if (za || zb || ia || ib || na || nb) begin
            r.spec = 1'b1;
            if (na || nb || (ia && zb) || (za && ib)) begin
                r.res   = 32'((emax << mw) | (one << (mw - 1)));
                r.fl[1] = sna || snb || (ia && zb) || (za && ib);
            end else if (ia || ib) r.res = 32'(sgl | (emax << mw));
            else r.res = 32'(sgl);
            return r;
        end
        p  = ((one << mw) | fa) * ((one << mw) | fb);
        e  = ea + eb - int'(bias);
        sh = mw;
        if (p >= (one << (2 * mw + 1))) begin sh = mw + 1; e++; end
        q    = p >> sh;
        rem  = p - (q << sh);
        half = one << (sh - 1);
        inx  = (rem != 0);
        case (rm)
            0:       inc = (rem > half) || ((rem == half) && q[0]);
            1:       inc = 0;
            2:       inc = inx && sg;
            3:       inc = inx && !sg;
            default: inc = (rem >= half);
        endcase
        if (inc) q++;
        if (q == (one << (mw + 1))) begin q = one << mw; e++; end
        maxf = sgl | ((emax - 1) << mw) | ((one << mw) - 1);
        inf  = sgl | (emax << mw);
        if (e >= emax) begin
            r.fl  = 4'b1001;
            r.res = (rm == 1 || (rm == 2 && !sg) || (rm == 3 && sg)) ? 32'(maxf) : 32'(inf);
        end else if (e <= 0) begin
            r.fl  = 4'b0101;
            r.res = 32'(sgl);
        end else begin
            r.fl  = {3'b000, inx};
            r.res = 32'(sgl | (longint'(e) << mw) | (q - (one << mw)));
        end
        return r;
    endfunction

    function automatic logic busy_of(input bit h);
        return h ? bus_h.busy : bus_s.busy;
    endfunction
    function automatic logic done_of(input bit h);
        return h ? bus_h.done : bus_s.done;
    endfunction
    function automatic logic [31:0] result_of(input bit h);
        return h ? 32'(bus_h.result) : bus_s.result;
    endfunction
    function automatic logic [31:0] flags_of(input bit h);
        return h ? 32'({bus_h.overflow, bus_h.underflow, bus_h.invalid, bus_h.inexact})
                 : 32'({bus_s.overflow, bus_s.underflow, bus_s.invalid, bus_s.inexact});
    endfunction

    task automatic drive(input bit h, input logic st, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] rm);
        if (h) begin
            bus_h.start = st; bus_h.a = a[15:0]; bus_h.b = b[15:0]; bus_h.rm = rm;
        end else begin
            bus_s.start = st; bus_s.a = a; bus_s.b = b; bus_s.rm = rm;
        end
    endtask

    // Noisy issues keep start high with garbage operands after acceptance; the DUT must ignore them.
    task automatic issue(input bit h, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] rm, input bit noisy);
        exp_t e;
        int n;
        e = model(a, b, rm, h ? 5 : 8, h ? 10 : 23);
        if (h) q_h.push_back(e); else q_s.push_back(e);
        @(negedge clk);
        drive(h, 1'b1, a, b, rm);
        @(posedge clk); #1;
        chk("busy_after_start", 32'(busy_of(h)), 32'd1);
        if (noisy) drive(h, 1'b1, ~a, ~b, rm ^ 3'b001);
        else       drive(h, 1'b0, a, b, rm);
        n = 0;
        while (!done_of(h) && n < 20) begin
            @(posedge clk); #1;
            drive(h, 1'b0, a, b, rm);
            n++;
        end
        chk("latency", 32'(n), e.spec ? 32'd1 : 32'd4);
        @(posedge clk); #1;
        chk("busy_back_idle", 32'(busy_of(h)), 32'd0);
        chk("result_hold", result_of(h), e.res);
    endtask

    function automatic logic [31:0] rnd_s();
        logic [31:0] sp[7] = '{32'h0, 32'h80000000, 32'h7F800000, 32'hFF800000,
                              32'h7FC00000, 32'h7F800001, 32'h00000123};
        int k = $urandom_range(0, 7);
        if (k == 0) return sp[$urandom_range(0, 6)];
        if (k == 1) return $urandom;
        return {1'($urandom), 8'($urandom_range(60, 190)), 23'($urandom)};
    endfunction

    function automatic logic [31:0] rnd_h();
        int k = $urandom_range(0, 5);
        if (k == 0) return 32'($urandom_range(0, 65535));
        return {16'h0, 1'($urandom), 5'($urandom_range(6, 24)), 10'($urandom)};
    endfunction

    always @(negedge clk) begin
        if (bus_s.done) begin
            if (q_s.size() == 0) chk("spurious_done_s", 32'd1, 32'd0);
            else begin
                e_s = q_s.pop_front();
                chk("result_s", bus_s.result, e_s.res);
                chk("flags_s", flags_of(1'b0), 32'(e_s.fl));
            end
        end
        if (bus_h.done) begin
            if (q_h.size() == 0) chk("spurious_done_h", 32'd1, 32'd0);
            else begin
                e_h = q_h.pop_front();
                chk("result_h", 32'(bus_h.result), e_h.res);
                chk("flags_h", flags_of(1'b1), 32'(e_h.fl));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        drive(1'b1, 1'b0, 32'h0, 32'h0, 3'b000);
        #12;
        chk("rst_busy", 32'(bus_s.busy), 32'd0);
        chk("rst_done", 32'(bus_s.done), 32'd0);
        chk("rst_result", bus_s.result, 32'd0);
        chk("rst_flags", flags_of(1'b0), 32'd0);
        chk("rst_result_h", 32'(bus_h.result), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        issue(0, 32'h3FC00000, 32'h40000000, 3'b000, 1);
        issue(0, 32'h7F800000, 32'h00000000, 3'b000, 0);
        issue(0, 32'h7F800001, 32'h3F800000, 3'b000, 1);
        issue(0, 32'h3F800001, 32'h3F800001, 3'b000, 0);
        issue(0, 32'h3F800001, 32'h3F800001, 3'b001, 0);
        issue(0, 32'h3F800001, 32'h3F800001, 3'b011, 0);
        issue(0, 32'h3F800001, 32'h3FC00000, 3'b000, 0);
        issue(0, 32'h3F800001, 32'h3FC00000, 3'b100, 0);
        issue(0, 32'h3F800001, 32'h3FC00000, 3'b110, 0);
        issue(0, 32'h7F7FFFFF, 32'h40000000, 3'b000, 0);
        issue(0, 32'h7F7FFFFF, 32'h40000000, 3'b001, 0);
        issue(0, 32'hFF7FFFFF, 32'h40000000, 3'b010, 0);
        issue(0, 32'hFF7FFFFF, 32'h40000000, 3'b011, 0);
        issue(0, 32'h80800000, 32'h3F000000, 3'b000, 0);
        issue(1, 32'h3C00, 32'h4000, 3'b000, 0);
        issue(1, 32'h7BFF, 32'h4000, 3'b000, 1);

        // Abort an operation while it sits in NORM
        @(negedge clk);
        drive(0, 1'b1, 32'h40400000, 32'h40000000, 3'b000);
        @(posedge clk); #1;
        drive(0, 1'b0, 32'h40400000, 32'h40000000, 3'b000);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus_s.busy), 32'd0);
        chk("abort_result", bus_s.result, 32'd0);
        chk("abort_flags", flags_of(1'b0), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", 32'(bus_s.done), 32'd0);
        end
        rst_n = 1'b1;
        issue(0, 32'h40000000, 32'h40000000, 3'b000, 0);

        for (int i = 0; i < 40; i++)
            issue(0, rnd_s(), rnd_s(), 3'($urandom_range(0, 7)), (i % 3) == 0);
        for (int i = 0; i < 20; i++)
            issue(1, rnd_h(), rnd_h(), 3'($urandom_range(0, 7)), (i % 4) == 0);

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(q_s.size() + q_h.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
